// File: rtl/rom_fetch_arbiter_pkg.sv
// Shared definitions for the program-ROM fetch arbiter.
// Holds the arbiter state encoding, the grant identifiers and the default
// SDRAM word bases of the two program ROMs. The SDRAM loader uses the same
// base constants so that the image offsets always match.
package rom_fetch_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_P = 2'd1,
    BUSY_S = 2'd2
  } arb_state_t;

  localparam logic GRANT_P = 1'b0;
  localparam logic GRANT_S = 1'b1;

  localparam int          ROM_AW_DEF    = 24;
  localparam logic [23:0] MAIN_BASE_DEF = 24'h000000;
  localparam logic [23:0] SND_BASE_DEF  = 24'h040000;

endpackage

// File: rtl/rom_fetch_arbiter_client.sv
// Per-CPU side of the ROM fetch arbiter.
// Tracks whether the current bus cycle has already been served, detects a
// bus cycle that ends before its read returns, captures read data and
// drives the registered, as_n-gated DTACK.
// Ports:
//   clk, reset_n  clock and asynchronous active-low reset
//   cs, as_n      decoded ROM select and address strobe of this CPU
//   busy          arbiter is currently running a read for this CPU
//   rom_valid     read data strobe from the SDRAM ROM channel
//   rom_data      read data from the SDRAM ROM channel
//   pending       this CPU wants a ROM read now
//   dtack_n       data acknowledge to the CPU (active low)
//   dout          last data delivered to this CPU
module rom_port_client
  import rom_fetch_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cs,
  input  logic        as_n,
  input  logic        busy,
  input  logic        rom_valid,
  input  logic [15:0] rom_data,
  output logic        pending,
  output logic        dtack_n,
  output logic [15:0] dout
);

  logic        served_q, served_d;
  logic        dtack_q, dtack_d;
  logic        aborted_q, aborted_d;
  logic [15:0] dout_q, dout_d;
  logic        deliver;

  always_comb begin
    // Data goes to the CPU only if its bus cycle survived the whole read.
    deliver   = busy & rom_valid & ~as_n & ~aborted_q;
    // Once as_n has been seen high during the read, the read belongs to a
    // finished bus cycle even if as_n falls again before rom_valid.
    aborted_d = busy & ~rom_valid & (aborted_q | as_n);
    served_d  = as_n ? 1'b0 : (served_q | deliver);
    dtack_d   = as_n ? 1'b0 : (dtack_q | deliver);
    dout_d    = deliver ? rom_data : dout_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      served_q  <= 1'b0;
      dtack_q   <= 1'b0;
      aborted_q <= 1'b0;
      dout_q    <= 16'h0000;
    end else begin
      served_q  <= served_d;
      dtack_q   <= dtack_d;
      aborted_q <= aborted_d;
      dout_q    <= dout_d;
    end
  end

  assign pending = cs & ~as_n & ~served_q;
  // The CPU ends its cycle by raising as_n; release DTACK in that same cycle.
  assign dtack_n = ~(dtack_q & ~as_n);
  assign dout    = dout_q;

endmodule

// File: rtl/rom_fetch_arbiter.sv
// Program-ROM fetch arbiter between the main and the sound 68000.
// Turns each CPU's ROM chip select plus address strobe into a single word
// read on the shared SDRAM ROM port, splits ties round-robin and returns
// data with a registered DTACK.
//
//   state  | meaning
//   -------+-------------------------------------------------
//   IDLE   | no read outstanding, choosing the next requester
//   BUSY_P | read for the main CPU outstanding on the port
//   BUSY_S | read for the sound CPU outstanding on the port
//
// Ports:
//   clk, reset_n                    clock, asynchronous active-low reset
//   m68kp_rom_cs/as_n/a             main CPU select, strobe, byte address
//   m68kp_rom_dtack_n/rom_dout      main CPU acknowledge and read data
//   m68ks_rom_cs/as_n/a             sound CPU select, strobe, byte address
//   m68ks_rom_dtack_n/rom_dout      sound CPU acknowledge and read data
//   rom_req, rom_addr               read request level and word address
//   rom_valid, rom_data             read completion pulse and data
module rom_fetch_arbiter
  import rom_fetch_arbiter_pkg::*;
#(
  parameter int                MEM_AW    = ROM_AW_DEF,
  parameter logic [MEM_AW-1:0] MAIN_BASE = MEM_AW'(MAIN_BASE_DEF),
  parameter logic [MEM_AW-1:0] SND_BASE  = MEM_AW'(SND_BASE_DEF)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              m68kp_rom_cs,
  input  logic              m68kp_as_n,
  input  logic [23:0]       m68kp_a,
  output logic              m68kp_rom_dtack_n,
  output logic [15:0]       m68kp_rom_dout,
  input  logic              m68ks_rom_cs,
  input  logic              m68ks_as_n,
  input  logic [23:0]       m68ks_a,
  output logic              m68ks_rom_dtack_n,
  output logic [15:0]       m68ks_rom_dout,
  output logic              rom_req,
  output logic [MEM_AW-1:0] rom_addr,
  input  logic              rom_valid,
  input  logic [15:0]       rom_data
);

  arb_state_t        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              rom_req_q, rom_req_d;
  logic [MEM_AW-1:0] rom_addr_q, rom_addr_d;

  logic              p_pend, s_pend;
  logic              grant_s;
  logic [MEM_AW-1:0] addr_p, addr_s;
  logic              unused_addr_bits;

  // Main ROM spans 512 KiB, sound ROM 128 KiB; upper bits and A0 are not
  // part of the word offset.
  assign addr_p = MAIN_BASE + MEM_AW'(m68kp_a[18:1]);
  assign addr_s = SND_BASE  + MEM_AW'(m68ks_a[16:1]);
  assign unused_addr_bits = ^{m68kp_a[23:19], m68kp_a[0], m68ks_a[23:17], m68ks_a[0]};

  rom_port_client u_client_p (
    .clk       (clk),
    .reset_n   (reset_n),
    .cs        (m68kp_rom_cs),
    .as_n      (m68kp_as_n),
    .busy      (state_q == BUSY_P),
    .rom_valid (rom_valid),
    .rom_data  (rom_data),
    .pending   (p_pend),
    .dtack_n   (m68kp_rom_dtack_n),
    .dout      (m68kp_rom_dout)
  );

  rom_port_client u_client_s (
    .clk       (clk),
    .reset_n   (reset_n),
    .cs        (m68ks_rom_cs),
    .as_n      (m68ks_as_n),
    .busy      (state_q == BUSY_S),
    .rom_valid (rom_valid),
    .rom_data  (rom_data),
    .pending   (s_pend),
    .dtack_n   (m68ks_rom_dtack_n),
    .dout      (m68ks_rom_dout)
  );

  // Sound wins when it is alone, or on a tie when main had the last tie.
  assign grant_s = s_pend & (~p_pend | (last_grant_q == GRANT_P));

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    rom_req_d    = rom_req_q;
    rom_addr_d   = rom_addr_q;
    unique case (state_q)
      IDLE: begin
        rom_req_d = 1'b0;
        if (p_pend | s_pend) begin
          state_d    = grant_s ? BUSY_S : BUSY_P;
          rom_req_d  = 1'b1;
          rom_addr_d = grant_s ? addr_s : addr_p;
          // Only ties move the round-robin pointer.
          if (p_pend & s_pend) begin
            last_grant_d = grant_s ? GRANT_S : GRANT_P;
          end
        end
      end
      BUSY_P, BUSY_S: begin
        if (rom_valid) begin
          state_d   = IDLE;
          rom_req_d = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        rom_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_S;
      rom_req_q    <= 1'b0;
      rom_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      rom_req_q    <= rom_req_d;
      rom_addr_q   <= rom_addr_d;
    end
  end

  assign rom_req  = rom_req_q;
  assign rom_addr = rom_addr_q;

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
module tb_rom_fetch_arbiter;

  typedef struct packed {
    logic [23:0] addr;
    logic [15:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        p_cs = 1'b0, p_as_n = 1'b1;
  logic [23:0] p_a = '0;
  logic        p_dtack_n;
  logic [15:0] p_dout;
  logic        s_cs = 1'b0, s_as_n = 1'b1;
  logic [23:0] s_a = '0;
  logic        s_dtack_n;
  logic [15:0] s_dout;
  logic        rom_req;
  logic [23:0] rom_addr;
  logic        rom_valid = 1'b0;
  logic [15:0] rom_data = '0;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int req_cnt = 0;
  int resp_lat = 3;
  logic resp_en = 1'b1;
  int stale_req = 0;
  int stale_ack = 0;
  int drv_cyc_p = 0;
  int dtack_cyc_p = 0;

  exp_t exp_q[$];
  int   accept_q[$];
  int   done_q[$];

  rom_fetch_arbiter dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .m68kp_rom_cs      (p_cs),
    .m68kp_as_n        (p_as_n),
    .m68kp_a           (p_a),
    .m68kp_rom_dtack_n (p_dtack_n),
    .m68kp_rom_dout    (p_dout),
    .m68ks_rom_cs      (s_cs),
    .m68ks_as_n        (s_as_n),
    .m68ks_a           (s_a),
    .m68ks_rom_dtack_n (s_dtack_n),
    .m68ks_rom_dout    (s_dout),
    .rom_req           (rom_req),
    .rom_addr          (rom_addr),
    .rom_valid         (rom_valid),
    .rom_data          (rom_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Downstream SDRAM model: pops the expected read, checks its address and
  // answers resp_lat cycles later with the scoreboard data.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rom_req && resp_en) begin
        req_cnt++;
        accept_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("unexpected_req", 32'd1, 32'd0);
          e = '0;
        end else begin
          e = exp_q.pop_front();
          chk("rom_addr", 32'(rom_addr), 32'(e.addr));
        end
        repeat (resp_lat - 1) @(negedge clk);
        rom_valid = 1'b1;
        rom_data  = e.data;
        @(negedge clk);
        rom_valid = 1'b0;
        done_q.push_back(cyc);
        chk("req_drop", 32'(rom_req), 32'd0);
      end else if (stale_req != stale_ack) begin
        rom_valid = 1'b1;
        rom_data  = 16'hDEAD;
        @(negedge clk);
        rom_valid = 1'b0;
        stale_ack = stale_req;
      end
    end
  end

  task automatic expect_rd(input logic [23:0] addr, input logic [15:0] data);
    exp_t e;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic set_bus(input int cpu, input logic cs, input logic as_n, input logic [23:0] a);
    if (cpu == 0) begin
      p_cs = cs; p_as_n = as_n; p_a = a;
    end else begin
      s_cs = cs; s_as_n = as_n; s_a = a;
    end
  endtask

  function automatic logic get_dtack(input int cpu);
    return (cpu == 0) ? p_dtack_n : s_dtack_n;
  endfunction

  function automatic logic [15:0] get_dout(input int cpu);
    return (cpu == 0) ? p_dout : s_dout;
  endfunction

  // One CPU bus cycle: strobe low, wait for DTACK, hold, then strobe high.
  task automatic do_read(input int cpu, input logic [23:0] a, input logic [15:0] exp_d,
                         input int hold);
    int n;
    @(negedge clk);
    set_bus(cpu, 1'b1, 1'b0, a);
    if (cpu == 0) drv_cyc_p = cyc;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (get_dtack(cpu) !== 1'b0 && n < 64);
    if (get_dtack(cpu) !== 1'b0) begin
      chk(cpu == 0 ? "dtack_timeout_p" : "dtack_timeout_s", 32'd1, 32'd0);
    end else begin
      if (cpu == 0) dtack_cyc_p = cyc;
      chk(cpu == 0 ? "dout_p" : "dout_s", 32'(get_dout(cpu)), 32'(exp_d));
    end
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      chk("dtack_hold", 32'(get_dtack(cpu)), 32'd0);
    end
    set_bus(cpu, 1'b0, 1'b1, a);
    #1;
    chk(cpu == 0 ? "dtack_rel_p" : "dtack_rel_s", 32'(get_dtack(cpu)), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"},    32'(rom_req),   32'd0);
    chk({tag, "_addr"},   32'(rom_addr),  32'd0);
    chk({tag, "_dtackp"}, 32'(p_dtack_n), 32'd1);
    chk({tag, "_dtacks"}, 32'(s_dtack_n), 32'd1);
    chk({tag, "_doutp"},  32'(p_dout),    32'd0);
    chk({tag, "_douts"},  32'(s_dout),    32'd0);
  endtask

  initial begin
    int ba, bd, r0, n;
    logic bad;

    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");
    reset_n = 1'b1;
    @(negedge clk);

    // Single main read, latency and DTACK timing.
    resp_lat = 3;
    ba = accept_q.size(); bd = done_q.size();
    expect_rd(24'h000080, 16'hBEEF);
    do_read(0, 24'h000100, 16'hBEEF, 0);
    chk("req_lat", 32'(accept_q[ba] - drv_cyc_p), 32'd1);
    chk("dtack_lat", 32'(dtack_cyc_p), 32'(done_q[bd]));

    // Tie after reset: main first, sound one IDLE cycle later.
    resp_lat = 2;
    ba = accept_q.size(); bd = done_q.size();
    expect_rd(24'h000102, 16'h1111);
    expect_rd(24'h040100, 16'h2222);
    fork
      do_read(0, 24'h000204, 16'h1111, 0);
      do_read(1, 24'h000200, 16'h2222, 0);
    join
    chk("tie1_gap", 32'(accept_q[ba + 1] - done_q[bd]), 32'd1);

    // Repeated tie: sound first now.
    ba = accept_q.size(); bd = done_q.size();
    expect_rd(24'h04FFFF, 16'h4444);
    expect_rd(24'h000008, 16'h3333);
    fork
      do_read(0, 24'h000010, 16'h3333, 0);
      do_read(1, 24'h01FFFE, 16'h4444, 0);
    join
    chk("tie2_gap", 32'(accept_q[ba + 1] - done_q[bd]), 32'd1);

    // One read per bus cycle even with a long strobe.
    r0 = req_cnt;
    expect_rd(24'h03FFFF, 16'h5555);
    do_read(0, 24'h07FFFE, 16'h5555, 20);
    chk("hold_one_req", 32'(req_cnt - r0), 32'd1);
    expect_rd(24'h03FFFF, 16'h6666);
    do_read(0, 24'h07FFFE, 16'h6666, 0);
    chk("hold_second_req", 32'(req_cnt - r0), 32'd2);

    // Sound aborts before the data returns.
    resp_lat = 6;
    r0 = req_cnt;
    expect_rd(24'h040010, 16'h1234);
    @(negedge clk);
    set_bus(1, 1'b1, 1'b0, 24'h000020);
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (req_cnt == r0 && n < 20);
    chk("abort_req_seen", 32'(req_cnt - r0), 32'd1);
    set_bus(1, 1'b0, 1'b1, 24'h000020);
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (s_dtack_n !== 1'b1) bad = 1'b1;
    end
    chk("abort_dtack", 32'(bad), 32'd0);
    chk("abort_dout", 32'(s_dout), 32'h4444);
    chk("abort_idle", 32'(rom_req), 32'd0);
    chk("abort_consumed", 32'(exp_q.size()), 32'd0);
    chk("abort_no_retry", 32'(req_cnt - r0), 32'd1);
    resp_lat = 2;
    expect_rd(24'h000001, 16'h7777);
    do_read(0, 24'h000002, 16'h7777, 0);

    // Reset in BUSY_P, then a stale response.
    resp_en = 1'b0;
    @(negedge clk);
    set_bus(0, 1'b1, 1'b0, 24'h000400);
    @(negedge clk);
    chk("busy_before_rst", 32'(rom_req), 32'd1);
    chk("addr_before_rst", 32'(rom_addr), 32'h000200);
    #2;
    reset_n = 1'b0;
    set_bus(0, 1'b0, 1'b1, 24'h000400);
    #1;
    chk_reset_outputs("midrst");
    @(negedge clk);
    reset_n = 1'b1;
    stale_req++;
    n = 0;
    while (stale_ack != stale_req && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("stale_sent", 32'(stale_ack), 32'(stale_req));
    repeat (2) @(negedge clk);
    chk_reset_outputs("stale");
    resp_en = 1'b1;

    // Non-ROM cycle is ignored.
    r0 = req_cnt;
    bad = 1'b0;
    set_bus(0, 1'b0, 1'b0, 24'h000100);
    repeat (10) begin
      @(negedge clk);
      if (rom_req !== 1'b0 || p_dtack_n !== 1'b1) bad = 1'b1;
    end
    set_bus(0, 1'b0, 1'b1, 24'h000100);
    chk("nonrom_quiet", 32'(bad), 32'd0);
    chk("nonrom_no_req", 32'(req_cnt - r0), 32'd0);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
